mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Data-memory responder: the memory-side end of the load/store request interface used by the pipelined float processor.
- Accepts ld/st requests over a valid/ready handshake and buffers them in an in-order request queue.
- Performs each access after a programmable latency and returns one response per request over a second valid/ready handshake.
- Lets the processor core move from its zero-latency internal data memory to a realistic multi-cycle memory.

Parameters:
ADDR_BITS, 16, number of address bits actually decoded; memory holds 2^ADDR_BITS 16-bit words
LATENCY, 2, cycles from start of service to response; legal range 1..15
QDEPTH, 4, request queue entries; power of two, at least 2

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  queue can accept a request
req_write  in  1  1 = store (st), 0 = load (ld)
req_addr  in  16  word address; bits above ADDR_BITS are ignored
req_data  in  16  store data; ignored for loads
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes the response
rsp_write  out  1  echoes req_write of the request being answered
rsp_data  out  16  load: memory word read; store: the data written
busy  out  1  queue non-empty or FSM not IDLE

Behaviour:
- Reset asserted (reset low):
  - queue emptied; FSM forced to IDLE; counter cleared.
  - rsp_valid=0, rsp_write=0, rsp_data=0, busy=0, req_ready=0 while reset is held.
  - Memory contents are NOT cleared.
- Reset is asynchronous: an in-flight request or a pending response is discarded with no memory write. A store whose write edge was already taken is kept.
- After reset is released, req_ready=1 from the first cycle.
- Accept: a request is accepted at a rising edge where req_valid and req_ready are both 1; that edge writes {write, addr, data} into the queue tail.
- req_ready = (count != QDEPTH). It depends on the registered count only; there is no same-cycle pass-through when the queue is full, even if a pop occurs on that edge.
- Simultaneous push and pop on one edge leaves count unchanged.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if the queue is non-empty, go to WAIT next edge with cnt=LATENCY-1.
  - WAIT: cnt decrements each edge. At the edge where cnt==0:
    - perform the access at addr[ADDR_BITS-1:0];
    - load: rsp_data <= mem[addr]; store: mem[addr] <= data and rsp_data <= data;
    - rsp_write <= entry write bit; pop the queue head; go to RESP with rsp_valid <= 1.
  - RESP: rsp_valid=1 and rsp_data/rsp_write are held stable until rsp_valid && rsp_ready at an edge. On that edge:
    - if the queue is non-empty (including an entry pushed on that same edge): go to WAIT, cnt=LATENCY-1, rsp_valid <= 0;
    - otherwise: go to IDLE, rsp_valid <= 0.
- Latency: a request accepted at edge N into an empty idle block raises rsp_valid at edge N+1+LATENCY.
- Sustained throughput is one request per LATENCY+1 cycles, plus any backpressure cycles.
- Ordering: strictly in order. A load after a store to the same address returns the stored value.
- Backpressure: while rsp_ready=0, the queue keeps accepting requests until full. No request is ever dropped.
- Address wrap: addresses are taken modulo 2^ADDR_BITS.
- busy = (count!=0) || (state!=IDLE).

Decomposition:
- Shared package holds:
  - WORD width (16);
  - the queue entry layout {write, addr[15:0], data[15:0]} = 33 bits;
  - FSM state encodings IDLE/WAIT/RESP.
  - The processor core uses the same WORD definition.
- Sub-module req_fifo(QDEPTH, width 33):
  - ports: push, pop, din, dout (head), full, empty, count;
  - registered pointers with an extra wrap bit.
- mem_responder contains the FSM, counter and memory array.

Test Plan:
- Reset release, then store addr 0x0010 data 0x3F80 followed by load addr 0x0010, rsp_ready=1, LATENCY=2 -> store response at accept+3 with rsp_write=1, rsp_data=0x3F80; load response 3 cycles later with rsp_data=0x3F80, rsp_write=0.
- Hold rsp_ready=0 and issue 6 back-to-back loads (QDEPTH=4) -> req_ready drops after the 5th accept (4 queued + 1 in service). Release rsp_ready -> all 6 responses arrive in order; rsp_data is stable while stalled.
- Load addr 0x1234 with ADDR_BITS=8 after storing 0xABCD at addr 0x0034 -> rsp_data=0xABCD (wrap).
- Assert reset mid-WAIT of a store to 0x0005 with data 0x1111 -> rsp_valid=0, busy=0, queue empty; a subsequent load of 0x0005 returns its prior contents.
- LATENCY=1, continuous requests with rsp_ready=1 -> one response every 2 cycles; a push on the same edge as a RESP handshake goes straight to WAIT with no IDLE cycle.

Source files
------------

// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ==== mem_responder_pkg : word width, request-queue entry layout, FSM states (rev 1.0) ====

package mem_responder_pkg;

  localparam int C_WORD = 16;

  typedef logic [C_WORD-1:0] word_t;

  // Queue entry, MSB first: {write, addr, data}
  typedef struct packed {
    logic  write;
    word_t addr;
    word_t data;
  } req_entry_t;

  localparam int C_ENTRY_W = $bits(req_entry_t);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mem_responder_req_fifo.sv
`default_nettype none
// ==== req_fifo : in-order request queue, pointers carry an extra wrap bit (rev 1.0) ====

module req_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_din,
  output logic [WIDTH-1:0]         o_dout,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int              C_PW   = $clog2(DEPTH);
  localparam logic [C_PW:0]   C_FULL = DEPTH[C_PW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [C_PW:0]    r_wr_ptr;
  logic [C_PW:0]    r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_count = r_wr_ptr - r_rd_ptr;
  assign o_full  = (o_count == C_FULL);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_dout  = r_mem[r_rd_ptr[C_PW-1:0]];

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: only slots between the pointers are ever read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[C_PW-1:0]] <= i_din;
  end

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ==== mem_responder : queued ld/st memory responder with programmable latency (rev 1.0) ====

module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_BITS = 16,
  parameter int LATENCY   = 2,
  parameter int QDEPTH    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [C_WORD-1:0] req_addr,
  input  logic [C_WORD-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [C_WORD-1:0] rsp_data,
  output logic              busy
);

  localparam int         C_CW       = $clog2(QDEPTH) + 1;
  localparam logic [3:0] C_CNT_INIT = 4'(LATENCY - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_nxt;
  logic                 r_rsp_valid;
  logic                 r_rsp_write;
  word_t                r_rsp_data;
  word_t                r_mem [2**ADDR_BITS];

  req_entry_t           w_din;
  req_entry_t           w_head;
  logic                 w_push;
  logic                 w_access;
  logic                 w_full;
  logic                 w_empty;
  logic [C_CW-1:0]      w_count;
  logic [ADDR_BITS-1:0] w_maddr;

  // Ready is held low while reset is asserted; otherwise only the registered fill level matters.
  assign req_ready = reset && !w_full;
  assign w_push    = req_valid && req_ready;
  assign w_din     = {req_write, req_addr, req_data};
  assign w_maddr   = w_head.addr[ADDR_BITS-1:0];

  req_fifo #(
    .DEPTH (QDEPTH),
    .WIDTH (C_ENTRY_W)
  ) u_req_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_pop   (w_access),
    .i_din   (w_din),
    .o_dout  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_access    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_WAIT;
          w_cnt_nxt   = C_CNT_INIT;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_access    = 1'b1;
          w_state_nxt = S_RESP;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        // A request pushed on the handshake edge starts service without an IDLE detour.
        if (rsp_ready) begin
          if (!w_empty || w_push) begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = C_CNT_INIT;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_access) begin
        r_rsp_valid <= 1'b1;
        r_rsp_write <= w_head.write;
        r_rsp_data  <= w_head.write ? w_head.data : r_mem[w_maddr];
      end else if ((r_state == S_RESP) && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  // Memory contents survive reset.
  always_ff @(posedge clk) begin
    if (w_access && w_head.write) r_mem[w_maddr] <= w_head.data;
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_data  = r_rsp_data;
  assign busy      = (w_count != '0) || (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ==== tb_mem_responder : request/response-level model with random traffic plus directed scenarios (rev 1.0) ====

module tb_mem_responder;

  localparam int AB  = 8;
  localparam int LAT = 2;
  localparam int QD  = 4;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [15:0] req_addr  = 16'h0;
  logic [15:0] req_data  = 16'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_write;
  logic        busy;
  logic [15:0] rsp_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_responder #(
    .ADDR_BITS (AB),
    .LATENCY   (LAT),
    .QDEPTH    (QD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting on the DUT (t=%0t)", nm, $time);
  endtask

  // ---------------- behavioural model (per request: accept edge -> service start -> response) ----
  typedef struct {
    logic        w;
    logic [15:0] a;
    logic [15:0] d;
    int          acc;
  } req_t;

  req_t        mq[$];
  logic [15:0] mmem [256];
  int          cyc     = 0;
  bit          m_svc   = 1'b0;
  int          m_due   = 0;
  bit          m_rv    = 1'b0;
  bit          m_rw    = 1'b0;
  logic [15:0] m_rd    = 16'h0;
  int          m_lastH = -1000;

  always @(posedge clk) begin
    req_t h;
    int   s;
    bit   acc_ok;
    cyc++;
    if (!reset) begin
      mq.delete();
      m_svc   = 1'b0;
      m_rv    = 1'b0;
      m_rw    = 1'b0;
      m_rd    = 16'h0;
      m_lastH = -1000;
    end else begin
      acc_ok = req_valid && (mq.size() != QD);
      if (m_rv && rsp_ready) begin
        m_rv    = 1'b0;
        m_lastH = cyc;
      end
      if (m_svc && cyc == m_due) begin
        h = mq.pop_front();
        if (h.w) begin
          mmem[h.a[AB-1:0]] = h.d;
          m_rd = h.d;
        end else begin
          m_rd = mmem[h.a[AB-1:0]];
        end
        m_rw  = h.w;
        m_rv  = 1'b1;
        m_svc = 1'b0;
      end
      if (acc_ok) mq.push_back('{req_write, req_addr, req_data, cyc});
      // Service of the head starts at the last handshake if it was already queued then,
      // otherwise one edge after it was accepted; the response follows LAT edges later.
      if (!m_svc && !m_rv && mq.size() > 0) begin
        s     = (mq[0].acc <= m_lastH) ? m_lastH : mq[0].acc + 1;
        m_due = s + LAT;
        m_svc = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("rsp_valid", rsp_valid, m_rv);
    chk("req_ready", req_ready, reset && (mq.size() != QD));
    chk("busy", busy, (mq.size() != 0) || m_svc || m_rv);
    if (m_rv) begin
      chk("rsp_data", rsp_data, m_rd);
      chk("rsp_write", rsp_write, m_rw);
    end
    if (!reset) begin
      chk("rst_rsp_data", rsp_data, 16'h0);
      chk("rst_rsp_write", rsp_write, 1'b0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic w, input logic [15:0] a, input logic [15:0] d);
    bit ok;
    int g;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_data  = d;
    g = 0;
    do begin
      ok = req_ready;
      step();
      g++;
    end while (!ok && g < 200);
    if (!ok) timeout_fail("send");
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output logic [15:0] d, output logic w);
    int g;
    g = 0;
    while (!rsp_valid && g < 100) begin
      step();
      g++;
    end
    if (!rsp_valid) timeout_fail("wait_rsp");
    d = rsp_data;
    w = rsp_write;
    step();
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((busy || rsp_valid) && g < 400) begin
      step();
      g++;
    end
    if (busy || rsp_valid) timeout_fail("wait_idle");
  endtask

  initial begin
    logic [15:0] d;
    logic        w;
    int          acc;
    int          nr;
    int          g;
    bit          ok;

    rsp_ready = 1'b1;
    repeat (3) step();
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_req_ready", req_ready, 1'b0);
    chk("reset_busy", busy, 1'b0);
    reset = 1'b1;
    #1;
    chk("ready_after_release", req_ready, 1'b1);
    step();

    // Fill every decoded word so the model knows the whole memory image.
    for (int a = 0; a < 256; a++)
      send(1'b1, 16'(a) | (16'($urandom) & 16'hFF00), 16'($urandom));
    wait_idle();

    // Store then load of 0x0010: responses at accept+3 and 3 cycles later.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 16'h0010; req_data = 16'h3F80;
    step();
    req_write = 1'b0;
    step();
    req_valid = 1'b0;
    step();
    chk("st_not_early", rsp_valid, 1'b0);
    step();
    chk("st_rsp_valid", rsp_valid, 1'b1);
    chk("st_rsp_write", rsp_write, 1'b1);
    chk("st_rsp_data", rsp_data, 16'h3F80);
    step();
    chk("ld_gap1", rsp_valid, 1'b0);
    step();
    chk("ld_gap2", rsp_valid, 1'b0);
    step();
    chk("ld_rsp_valid", rsp_valid, 1'b1);
    chk("ld_rsp_write", rsp_write, 1'b0);
    chk("ld_rsp_data", rsp_data, 16'h3F80);
    step();
    wait_idle();

    // Backpressure: 5 accepts back to back, then full until responses drain.
    rsp_ready = 1'b0;
    acc = 0;
    g = 0;
    while (acc < 5 && g < 50) begin
      req_valid = 1'b1; req_write = 1'b0; req_addr = 16'(16'h0040 + acc);
      ok = req_ready;
      step();
      if (ok) acc++;
      g++;
    end
    chk("bp_accept_cycles", g, 5);
    chk("bp_ready_drop", req_ready, 1'b0);
    req_addr = 16'h0045;
    repeat (4) step();
    chk("bp_still_full", req_ready, 1'b0);
    chk("bp_rsp_pending", rsp_valid, 1'b1);
    rsp_ready = 1'b1;
    nr = 0;
    g = 0;
    while (nr < 6 && g < 100) begin
      ok = req_ready && req_valid;
      if (rsp_valid) nr++;
      step();
      if (ok) req_valid = 1'b0;
      g++;
    end
    chk("bp_rsp_count", nr, 6);
    req_valid = 1'b0;
    wait_idle();

    // Address wrap: 0x1234 aliases 0x0034 with 8 decoded bits.
    send(1'b1, 16'h0034, 16'hABCD);
    wait_rsp(d, w);
    send(1'b0, 16'h1234, 16'h0000);
    wait_rsp(d, w);
    chk("wrap_data", d, 16'hABCD);
    chk("wrap_write", w, 1'b0);
    wait_idle();

    // Reset during WAIT of a store discards it.
    send(1'b1, 16'h0005, 16'h2222);
    wait_rsp(d, w);
    wait_idle();
    send(1'b1, 16'h0005, 16'h1111);
    step();
    reset = 1'b0;
    #1;
    chk("midrst_rsp_valid", rsp_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_req_ready", req_ready, 1'b0);
    step();
    step();
    reset = 1'b1;
    step();
    chk("postrst_busy", busy, 1'b0);
    send(1'b0, 16'h0005, 16'h0000);
    wait_rsp(d, w);
    chk("rst_store_dropped", d, 16'h2222);
    wait_idle();

    // Random traffic with a reset in the middle.
    for (int c = 0; c < 2000; c++) begin
      req_valid = ($urandom_range(0, 9) < 6);
      req_write = 1'($urandom_range(0, 1));
      req_addr  = 16'($urandom);
      req_data  = 16'($urandom);
      rsp_ready = ($urandom_range(0, 9) < 7);
      if (c == 900) reset = 1'b0;
      if (c == 903) reset = 1'b1;
      step();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
